// File: rtl/state_reg_pkg.sv
// Shared definitions for the lane-serial state register: FSM encodings and
// the lane-index width helper.
package state_reg_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'b00;
   localparam state_t ST_ABSORB = 2'b01;
   localparam state_t ST_RUN    = 2'b10;
   localparam state_t ST_DONE   = 2'b11;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A single-lane configuration still needs a one-bit index.
   function automatic int lane_idx_w(input int lanes);
      return (lanes > 1) ? clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/state_reg_ctl_if.sv
// Bus bundle for state_reg_ctl: run control, lane absorb handshake, round
// function loop and result handshake.
interface state_reg_ctl_if #(
   parameter int WIDTH  = 128,
   parameter int LANE_W = 32,
   parameter int CNT_W  = 6
);
   logic              start;
   logic              init;
   logic              xor_mode;
   logic              abort;
   logic [LANE_W-1:0] load_data;
   logic              load_valid;
   logic              load_ready;
   logic [WIDTH-1:0]  rf_in;
   logic [WIDTH-1:0]  so;
   logic [CNT_W-1:0]  round;
   logic              busy;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output start, init, xor_mode, abort, load_data, load_valid, rf_in, out_ready,
      input  load_ready, so, round, busy, out_valid
   );

   modport slave (
      input  start, init, xor_mode, abort, load_data, load_valid, rf_in, out_ready,
      output load_ready, so, round, busy, out_valid
   );
endinterface

// File: rtl/state_reg_ctl_lane_insert.sv
// Combinational lane merge: writes or XORs one LANE_W slice of the state,
// selected by the lane index, leaving all other bits untouched.
module lane_insert #(
   parameter int WIDTH  = 128,
   parameter int LANE_W = 32,
   parameter int LANES  = WIDTH / LANE_W,
   parameter int IDX_W  = 2
) (
   input  logic [WIDTH-1:0]  so_i,
   input  logic [LANE_W-1:0] load_data_i,
   input  logic [IDX_W-1:0]  lane_cnt_i,
   input  logic              xor_mode_i,
   output logic [WIDTH-1:0]  so_o
);

   always_comb begin
      so_o = so_i;
      for (int k = 0; k < LANES; k++) begin
         if (lane_cnt_i == IDX_W'(k)) begin
            so_o[k*LANE_W +: LANE_W] = xor_mode_i ? (so_i[k*LANE_W +: LANE_W] ^ load_data_i)
                                                  : load_data_i;
         end
      end
   end

endmodule

// File: rtl/state_reg_ctl.sv
// Lane-serial permutation state register with absorb/run/done sequencing.
// Absorbs LANES lanes MSB-first, then applies exactly ROUNDS round updates.
//
//   state  | meaning
//   IDLE   | waiting for start; init reloads INIT_VALUE
//   ABSORB | accepting lanes, lane_cnt counts down to 0
//   RUN    | so <= rf_in every cycle, round counts 0..ROUNDS-1
//   DONE   | result held on so until out_ready
module state_reg_ctl
   import state_reg_pkg::*;
#(
   parameter int               WIDTH      = 128,
   parameter int               LANE_W     = 32,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   parameter int               ROUNDS     = 40,
   parameter int               CNT_W      = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   state_reg_ctl_if.slave bus
);

   localparam int LANES = WIDTH / LANE_W;
   localparam int IDX_W = lane_idx_w(LANES);

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   so_q,       so_d;
   logic [IDX_W-1:0]   lane_cnt_q, lane_cnt_d;
   logic [CNT_W-1:0]   round_q,    round_d;
   logic [WIDTH-1:0]   so_ins;

   lane_insert #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .IDX_W  (IDX_W)
   ) u_lane_insert (
      .so_i        (so_q),
      .load_data_i (bus.load_data),
      .lane_cnt_i  (lane_cnt_q),
      .xor_mode_i  (bus.xor_mode),
      .so_o        (so_ins)
   );

   always_comb begin
      state_d    = state_q;
      so_d       = so_q;
      lane_cnt_d = lane_cnt_q;
      round_d    = round_q;

      if (bus.abort) begin
         state_d    = ST_IDLE;
         lane_cnt_d = '0;
         round_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.init) so_d = INIT_VALUE;
               if (bus.start) begin
                  state_d    = ST_ABSORB;
                  lane_cnt_d = IDX_W'(LANES - 1);
               end
            end
            ST_ABSORB: begin
               if (bus.load_valid) begin
                  so_d = so_ins;
                  if (lane_cnt_q == '0) begin
                     state_d = ST_RUN;
                     round_d = '0;
                  end else begin
                     lane_cnt_d = lane_cnt_q - IDX_W'(1);
                  end
               end
            end
            ST_RUN: begin
               so_d = bus.rf_in;
               if (round_q == CNT_W'(ROUNDS - 1)) begin
                  state_d = ST_DONE;
                  round_d = '0;
               end else begin
                  round_d = round_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         so_q       <= INIT_VALUE;
         lane_cnt_q <= '0;
         round_q    <= '0;
      end else begin
         state_q    <= state_d;
         so_q       <= so_d;
         lane_cnt_q <= lane_cnt_d;
         round_q    <= round_d;
      end
   end

   assign bus.so         = so_q;
   assign bus.round      = round_q;
   assign bus.load_ready = (state_q == ST_ABSORB);
   assign bus.busy       = (state_q == ST_ABSORB) || (state_q == ST_RUN);
   assign bus.out_valid  = (state_q == ST_DONE);

endmodule
